// File: rtl/mm_pkg.sv
// Shared constants and FSM state type for the matrix-multiplier stream host.
package mm_pkg;
  localparam int MM_N         = 3;
  localparam int MM_ELEM_W    = 8;
  localparam int MM_NUM_ELEMS = 9;
  localparam int MM_MAT_W     = 72;

  localparam logic [3:0] MM_LAST_IDX = 4'(MM_NUM_ELEMS - 1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    CLEAR,
    RUN,
    DRAIN,
    ERROR
  } mm_state_e;
endpackage

// File: rtl/mm_byte_serializer.sv
// Holds a captured 72-bit result and emits it as nine valid/ready bytes,
// element 0 first. The loaded word is the block's result register.
module mm_byte_serializer
  import mm_pkg::*;
(
  input  logic                Clock,
  input  logic                reset,
  input  logic                load,
  input  logic [MM_MAT_W-1:0] load_data,
  output logic                m_valid,
  output logic [7:0]          m_data,
  input  logic                m_ready,
  output logic                last
);
  logic [MM_NUM_ELEMS-1:0][MM_ELEM_W-1:0] data_q, data_d;
  logic [3:0] idx_q, idx_d;
  logic       valid_q, valid_d;

  // Load a new word, or step the byte index on each accepted byte.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last    = 1'b0;
    if (load) begin
      data_d  = load_data;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && m_ready) begin
      if (idx_q == MM_LAST_IDX) begin
        last    = 1'b1;
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  // Result register, byte index and valid flag.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Data comes straight from registers, so it cannot move during a stall.
  assign m_valid = valid_q;
  assign m_data  = data_q[idx_q];
endmodule

// File: rtl/mm_stream_host.sv
// Byte-stream host for the 3x3 signed 8-bit multiplier: loads A then B,
// pulses the multiplier clear, runs it until done (with timeout), then
// streams C out. Optional cycle counter enabled by MM_STREAM_HOST_PERF_EN.
module mm_stream_host
  import mm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 8
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [7:0]          m_data,
  input  logic                m_ready,
  output logic                mm_clear,
  output logic                mm_enable,
  output logic [MM_MAT_W-1:0] mm_A,
  output logic [MM_MAT_W-1:0] mm_B,
  input  logic [MM_MAT_W-1:0] mm_C,
  input  logic                mm_done,
  output logic                busy,
  output logic                err,
  output logic [15:0]         perf_cycles
);
  mm_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [MM_NUM_ELEMS-1:0][MM_ELEM_W-1:0] a_q, a_d, b_q, b_d;
  logic [TO_W-1:0] to_q, to_d;
  logic s_ready_q, s_ready_d;
  logic clear_q, clear_d;
  logic enable_q, enable_d;
  logic err_q, err_d;
  logic ser_load, ser_last;
  logic s_fire;

  assign s_fire = s_valid && s_ready_q;

  // Next-state, deserializer writes, timeout and registered output decodes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    to_d     = to_q;
    err_d    = err_q;
    ser_load = 1'b0;
    case (state_q)
      LOAD_A: if (s_fire) begin
        a_d[idx_q] = s_data;
        if (idx_q == MM_LAST_IDX) begin
          idx_d   = '0;
          state_d = LOAD_B;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      LOAD_B: if (s_fire) begin
        b_d[idx_q] = s_data;
        if (idx_q == MM_LAST_IDX) begin
          idx_d   = '0;
          state_d = CLEAR;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      CLEAR: begin
        to_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        if (mm_done) begin
          ser_load = 1'b1;
          state_d  = DRAIN;
        end else begin
          to_d = to_q + 1'b1;
          if (to_d == TO_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      DRAIN:   if (ser_last) state_d = LOAD_A;
      ERROR:   state_d = ERROR;
      default: state_d = LOAD_A;
    endcase
    // Handshake/control outputs are decoded from the next state and registered.
    s_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    clear_d   = (state_d == CLEAR);
    enable_d  = (state_d == RUN);
  end

  // Control and data registers; reset discards any partial load.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD_A;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      to_q      <= '0;
      s_ready_q <= 1'b0;
      clear_q   <= 1'b0;
      enable_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      to_q      <= to_d;
      s_ready_q <= s_ready_d;
      clear_q   <= clear_d;
      enable_q  <= enable_d;
      err_q     <= err_d;
    end
  end

  mm_byte_serializer u_ser (
    .Clock     (Clock),
    .reset     (reset),
    .load      (ser_load),
    .load_data (mm_C),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .last      (ser_last)
  );

  assign s_ready   = s_ready_q;
  assign mm_clear  = clear_q;
  assign mm_enable = enable_q;
  assign mm_A      = a_q;
  assign mm_B      = b_q;
  assign err       = err_q;
  assign busy      = !((state_q == LOAD_A) && (idx_q == '0));

`ifdef MM_STREAM_HOST_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Saturating count over CLEAR and RUN; restarts when CLEAR is entered.
  always_comb begin
    perf_d = perf_q;
    if (state_q == LOAD_B && state_d == CLEAR)
      perf_d = '0;
    else if ((state_q == CLEAR || state_q == RUN) && perf_q != 16'hFFFF)
      perf_d = perf_q + 16'd1;
  end

  // Performance counter register.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif
endmodule
